ps2_disp_ctrl: RTL and testbench

- Sequences the two-digit 7-segment display path from the PS/2 keyboard byte stream.
- Parses make, break (F0) and extended (E0) scan codes.
- Presents the held key code, a key-press count, and a display enable to the segment drivers.
- Sits between the PS/2 receiver and the segment decoders; the segment drivers blank when disp_en is low.

---
 rtl/ps2_disp_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ps2_disp_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_disp_ctrl.sv
// ---------------------------------------------------------------------------
// PS2DispCtrl : scan-code sequencer for the two-digit 7-segment display path.
//
// Takes the byte stream from the PS/2 receiver, recognises make codes, break
// (F0) prefixes and extended (E0) prefixes, and presents the held key code,
// a count of distinct key presses and a display enable to the segment drivers.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   clrn     : asynchronous active-low reset
//   rx_data  : scan-code byte from the PS/2 receiver
//   rx_valid : rx_data valid, held by the producer until accepted
//   rx_ready : controller can accept a byte (transfer on rx_valid & rx_ready)
//   code_o   : last make code shown on the display
//   ext_o    : code_o was preceded by an E0 prefix
//   cnt_o    : count of distinct key presses, wraps modulo 2^CNT_W
//   disp_en  : display enable, high while a key is held
//
// Build option
//   PS2_DISP_TIMEOUT_EN : when defined, a held key that produces no byte for
//                         TIMEOUT_CYC cycles is treated as released.
// ---------------------------------------------------------------------------
module ps2_disp_ctrl #(
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [7:0]       code_o,
   output logic             ext_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             disp_en
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      BRK     = 2'd2
   } state_t;

   localparam logic [7:0] EXT_PREFIX = 8'hE0;
   localparam logic [7:0] BRK_PREFIX = 8'hF0;

   state_t           r_state,    w_stateNxt;
   state_t           r_brkFrom,  w_brkFromNxt;
   logic             r_extPend,  w_extPendNxt;
   logic [7:0]       r_code,     w_codeNxt;
   logic             r_ext,      w_extNxt;
   logic [CNT_W-1:0] r_cnt,      w_cntNxt;
   logic             r_dispEn,   w_dispEnNxt;
   logic             r_ready;
   logic             w_accept;
   logic             w_sameKey;

   assign w_accept  = rx_valid & r_ready;
   // A byte names the displayed key only if both the code and the E0 flag agree.
   assign w_sameKey = (rx_data == r_code) && (r_extPend == r_ext);

`ifdef PS2_DISP_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] r_toCnt, w_toCntNxt;
   logic            w_timeout;

   // Timeout only fires on an edge with no accepted byte, so a byte arriving
   // on the timeout edge wins and the key stays held.
   assign w_timeout = (r_state == PRESSED) && (r_toCnt == TO_MAX) && !w_accept;

   // Stuck-key counter: runs only while a key is held, restarts on any byte.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_toCnt <= '0;
      else       r_toCnt <= w_toCntNxt;
   end

   always_comb begin
      w_toCntNxt = '0;
      if (r_state == PRESSED && !w_accept && !w_timeout)
         w_toCntNxt = r_toCnt + 1'b1;
   end
`else
   logic w_timeout;
   assign w_timeout = 1'b0;
`endif

   // State and output registers. rx_ready sits low for exactly one cycle after
   // each accepted byte and comes up on the first edge after reset release.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state   <= IDLE;
         r_brkFrom <= IDLE;
         r_extPend <= 1'b0;
         r_code    <= '0;
         r_ext     <= 1'b0;
         r_cnt     <= '0;
         r_dispEn  <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_stateNxt;
         r_brkFrom <= w_brkFromNxt;
         r_extPend <= w_extPendNxt;
         r_code    <= w_codeNxt;
         r_ext     <= w_extNxt;
         r_cnt     <= w_cntNxt;
         r_dispEn  <= w_dispEnNxt;
         r_ready   <= ~w_accept;
      end
   end

   // Scan-code parser. E0 only arms the extended flag; F0 moves to BRK and
   // remembers where to return; any other byte is a make or a release code.
   always_comb begin
      w_stateNxt   = r_state;
      w_brkFromNxt = r_brkFrom;
      w_extPendNxt = r_extPend;
      w_codeNxt    = r_code;
      w_extNxt     = r_ext;
      w_cntNxt     = r_cnt;
      w_dispEnNxt  = r_dispEn;

      if (w_accept) begin
         if (rx_data == EXT_PREFIX) begin
            w_extPendNxt = 1'b1;
         end else if (rx_data == BRK_PREFIX) begin
            // A second F0 inside BRK must not overwrite the return state.
            if (r_state != BRK) begin
               w_brkFromNxt = r_state;
               w_stateNxt   = BRK;
            end
         end else begin
            w_extPendNxt = 1'b0;
            case (r_state)
               IDLE: begin
                  w_codeNxt   = rx_data;
                  w_extNxt    = r_extPend;
                  w_cntNxt    = r_cnt + 1'b1;
                  w_dispEnNxt = 1'b1;
                  w_stateNxt  = PRESSED;
               end
               PRESSED: begin
                  // Typematic repeats of the held key are not new presses.
                  if (!w_sameKey) begin
                     w_codeNxt = rx_data;
                     w_extNxt  = r_extPend;
                     w_cntNxt  = r_cnt + 1'b1;
                  end
               end
               BRK: begin
                  // Only releasing the displayed key blanks the display;
                  // releases of other keys just return to where we were.
                  if (r_brkFrom == PRESSED && w_sameKey) begin
                     w_dispEnNxt = 1'b0;
                     w_stateNxt  = IDLE;
                  end else begin
                     w_stateNxt  = r_brkFrom;
                  end
               end
               default: w_stateNxt = IDLE;
            endcase
         end
      end else if (w_timeout) begin
         w_dispEnNxt  = 1'b0;
         w_stateNxt   = IDLE;
         w_extPendNxt = 1'b0;
      end
   end

   assign rx_ready = r_ready;
   assign code_o   = r_code;
   assign ext_o    = r_ext;
   assign cnt_o    = r_cnt;
   assign disp_en  = r_dispEn;

endmodule

// File: tb/tb_ps2_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tbPs2DispCtrl : self-checking bench for ps2_disp_ctrl.
//
// Bytes are driven through the valid/ready handshake; the expected display
// state after each byte is pushed to a queue when the byte is driven and
// popped and compared once the DUT has accepted it.
// ---------------------------------------------------------------------------
module tb_ps2_disp_ctrl;

   localparam int CNT_W = 8;

   typedef struct packed {
      logic [7:0]       code;
      logic             ext;
      logic [CNT_W-1:0] cnt;
      logic             en;
   } exp_t;

   logic             clk;
   logic             clrn;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       code_o;
   logic             ext_o;
   logic [CNT_W-1:0] cnt_o;
   logic             disp_en;

   exp_t expQ[$];
   int   checkCount;
   int   errorCount;

   ps2_disp_ctrl #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk      (clk),
      .clrn     (clrn),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .code_o   (code_o),
      .ext_o    (ext_o),
      .cnt_o    (cnt_o),
      .disp_en  (disp_en)
   );

   // 100 MHz free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Holds reset for three cycles, releases it, and waits for rx_ready.
   task automatic applyReset();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      clrn     = 1'b0;
      repeat (3) @(posedge clk);
      #1 clrn = 1'b1;
      @(posedge clk);
      #1;
      expQ.delete();
   endtask

   // Drives one byte, waits (bounded) for acceptance, then compares the DUT
   // outputs against the expectation queued for this byte.
   task automatic applyStimulus(input string tag, input logic [7:0] b,
                                input logic [7:0] eCode, input logic eExt,
                                input logic [CNT_W-1:0] eCnt, input logic eEn);
      exp_t e;
      bit   accepted;
      expQ.push_back('{code: eCode, ext: eExt, cnt: eCnt, en: eEn});
      rx_data  = b;
      rx_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (rx_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      e = expQ.pop_front();
      if (!accepted) begin
         checkOutput({tag, "_acceptTimeout"}, 32'd0, 32'd1);
      end else begin
         checkOutput({tag, "_code"}, 32'(code_o), 32'(e.code));
         checkOutput({tag, "_ext"},  32'(ext_o),  32'(e.ext));
         checkOutput({tag, "_cnt"},  32'(cnt_o),  32'(e.cnt));
         checkOutput({tag, "_en"},   32'(disp_en), 32'(e.en));
         checkOutput({tag, "_rdyLow"}, 32'(rx_ready), 32'd0);
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;

      // Reset then idle: outputs clear immediately, rx_ready on first edge.
      clrn = 1'b0;
      #2;
      checkOutput("rstCodeAsync", 32'(code_o), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstCode",  32'(code_o),   32'd0);
      checkOutput("rstExt",   32'(ext_o),    32'd0);
      checkOutput("rstCnt",   32'(cnt_o),    32'd0);
      checkOutput("rstEn",    32'(disp_en),  32'd0);
      checkOutput("rstReady", 32'(rx_ready), 32'd0);
      clrn = 1'b1;
      #2;
      checkOutput("relReadyPre", 32'(rx_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("relReadyPost", 32'(rx_ready), 32'd1);

      // Simple press and release.
      applyStimulus("press1C",   8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("breakF0",   8'hF0, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("release1C", 8'h1C, 8'h1C, 1'b0, 8'd1, 1'b0);

      // Typematic, extended key, foreign release, repeated prefixes.
      applyReset();
      applyStimulus("typ1",   8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("typ2",   8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("typ3",   8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("extE0",  8'hE0, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("extE0b", 8'hE0, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("ext75",  8'h75, 8'h75, 1'b1, 8'd2, 1'b1);
      applyStimulus("plain75",8'h75, 8'h75, 1'b0, 8'd3, 1'b1);
      applyStimulus("reE0",   8'hE0, 8'h75, 1'b0, 8'd3, 1'b1);
      applyStimulus("re75",   8'h75, 8'h75, 1'b1, 8'd4, 1'b1);
      applyStimulus("fgnF0",  8'hF0, 8'h75, 1'b1, 8'd4, 1'b1);
      applyStimulus("fgnF0b", 8'hF0, 8'h75, 1'b1, 8'd4, 1'b1);
      applyStimulus("fgn1C",  8'h1C, 8'h75, 1'b1, 8'd4, 1'b1);
      applyStimulus("relE0",  8'hE0, 8'h75, 1'b1, 8'd4, 1'b1);
      applyStimulus("relF0",  8'hF0, 8'h75, 1'b1, 8'd4, 1'b1);
      applyStimulus("rel75",  8'h75, 8'h75, 1'b1, 8'd4, 1'b0);
      applyStimulus("idleF0", 8'hF0, 8'h75, 1'b1, 8'd4, 1'b0);
      applyStimulus("idle33", 8'h33, 8'h75, 1'b1, 8'd4, 1'b0);
      applyStimulus("idle34", 8'h34, 8'h34, 1'b0, 8'd5, 1'b1);

      // Handshake: rx_valid held high, bytes presented back-to-back.
      applyReset();
      rx_data  = 8'h1C;
      rx_valid = 1'b1;
      checkOutput("hsReady1", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("hsReady2", 32'(rx_ready), 32'd0);
      checkOutput("hsCnt1",   32'(cnt_o),    32'd1);
      rx_data = 8'h32;
      @(posedge clk);
      #1;
      checkOutput("hsReady3", 32'(rx_ready), 32'd1);
      checkOutput("hsHold",   32'(code_o),   32'h1C);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checkOutput("hsCnt2",  32'(cnt_o),  32'd2);
      checkOutput("hsCode2", 32'(code_o), 32'h32);
      @(posedge clk);
      #1;
      checkOutput("hsOnce", 32'(cnt_o), 32'd2);

      // Counter wrap with alternating distinct keys.
      applyReset();
      for (int i = 0; i < 256; i++) begin
         applyStimulus("wrap", (i % 2 != 0) ? 8'h16 : 8'h15,
                       (i % 2 != 0) ? 8'h16 : 8'h15, 1'b0,
                       CNT_W'(i + 1), 1'b1);
      end
      checkOutput("wrapZero", 32'(cnt_o), 32'd0);

      // Reset between F0 and the code discards the partial release.
      applyStimulus("midF0", 8'hF0, 8'h16, 1'b0, 8'd0, 1'b1);
      clrn = 1'b0;
      @(posedge clk);
      #1 clrn = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus("post1C",  8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      applyStimulus("postTyp", 8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);

`ifdef PS2_DISP_TIMEOUT_EN
      // Stuck key: 16 idle cycles release the display.
      applyReset();
      applyStimulus("toPress", 8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      repeat (15) @(posedge clk);
      #1;
      checkOutput("toBefore", 32'(disp_en), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("toEn",   32'(disp_en), 32'd0);
      checkOutput("toCode", 32'(code_o),  32'h1C);
      checkOutput("toCnt",  32'(cnt_o),   32'd1);

      // A byte on the timeout edge keeps the key held.
      applyReset();
      applyStimulus("toPress2", 8'h1C, 8'h1C, 1'b0, 8'd1, 1'b1);
      repeat (15) @(posedge clk);
      #1;
      rx_data  = 8'h1C;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checkOutput("toRaceEn",  32'(disp_en), 32'd1);
      checkOutput("toRaceCnt", 32'(cnt_o),   32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
